// File: rtl/vector_to_degrees.sv
// Iterative CORDIC (vectoring mode) converting a signed cos/sin pair to an angle in degrees.
// Optional VECTOR_TO_DEGREES_SIGNED_EN reports the angle as two's complement -179..180.
module vector_to_degrees #(
  parameter int ITER = 10,
  parameter int W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] degrees,
  output logic       zero_vec,
  output logic       busy
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid holds with its data until out_ready is seen in HOLD.

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREROT,
    S_ITER,
    S_ROUND,
    S_HOLD
  } state_t;

  localparam logic [3:0]          LAST_I  = 4'(ITER - 1);
  localparam logic signed [W-1:0] Z_180   = 11520;
  localparam logic signed [W-1:0] HALF    = 32;
  localparam logic signed [W-1:0] DEG_360 = 360;
`ifdef VECTOR_TO_DEGREES_SIGNED_EN
  localparam logic signed [W-1:0] DEG_180 = 180;
`endif

  state_t state, state_nxt;

  logic signed [W-1:0] x, y, z;
  logic signed [W-1:0] x_ext, y_ext;
  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] z_rnd, d_raw, d_wrap, d_fin;
  logic [3:0]          iter_cnt;
  logic                zero_flag;

  // atan(2^-i) in 1/64 degree units
  function automatic logic signed [W-1:0] atan_tab(input logic [3:0] idx);
    logic signed [W-1:0] a;
    case (idx)
      4'd0:    a = 2880;
      4'd1:    a = 1700;
      4'd2:    a = 898;
      4'd3:    a = 456;
      4'd4:    a = 229;
      4'd5:    a = 115;
      4'd6:    a = 57;
      4'd7:    a = 29;
      4'd8:    a = 14;
      4'd9:    a = 7;
      4'd10:   a = 4;
      4'd11:   a = 2;
      default: a = 0;
    endcase
    return a;
  endfunction

  assign x_ext = {{(W-14){x_in[7]}}, x_in, 6'b0};
  assign y_ext = {{(W-14){y_in[7]}}, y_in, 6'b0};
  assign x_sh  = x >>> iter_cnt;
  assign y_sh  = y >>> iter_cnt;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_PREROT) || (state == S_ITER) || (state == S_ROUND);

  always_comb begin
    z_rnd  = z + HALF;
    d_raw  = z_rnd >>> 6;
    d_wrap = d_raw;
    if (d_raw < 0) begin
      d_wrap = d_raw + DEG_360;
    end else if (d_raw >= DEG_360) begin
      d_wrap = d_raw - DEG_360;
    end
    d_fin = d_wrap;
`ifdef VECTOR_TO_DEGREES_SIGNED_EN
    if (d_wrap > DEG_180) begin
      d_fin = d_wrap - DEG_360;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_PREROT;
      S_PREROT: state_nxt = S_ITER;
      S_ITER:   if (iter_cnt == LAST_I) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_HOLD;
      S_HOLD:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter_cnt  <= '0;
      zero_flag <= 1'b0;
      out_valid <= 1'b0;
      degrees   <= '0;
      zero_vec  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x <= x_ext;
            y <= y_ext;
          end
        end
        S_PREROT: begin
          zero_flag <= (x == 0) && (y == 0);
          iter_cnt  <= '0;
          // Left half-plane: rotate by 180 so the iterations only cover -90..90.
          if (x < 0) begin
            x <= -x;
            y <= -y;
            z <= Z_180;
          end else begin
            z <= '0;
          end
        end
        S_ITER: begin
          if (!y[W-1]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_tab(iter_cnt);
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_tab(iter_cnt);
          end
          iter_cnt <= iter_cnt + 4'd1;
        end
        S_ROUND: begin
          out_valid <= 1'b1;
          zero_vec  <= zero_flag;
          degrees   <= zero_flag ? 10'd0 : d_fin[9:0];
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            zero_vec  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_to_degrees.sv
// Directed and randomised checks of vector_to_degrees against an atan2 reference model.
module tb_vector_to_degrees;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] degrees;
  logic       zero_vec;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // {exact, zero, degrees 0..359}
  logic [11:0] exp_q[$];

  vector_to_degrees dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .degrees   (degrees),
    .zero_vec  (zero_vec),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic logic [9:0] fold(input logic [9:0] d);
`ifdef VECTOR_TO_DEGREES_SIGNED_EN
    if (d > 10'd180) return d - 10'd360;
`endif
    return d;
  endfunction

  function automatic int unfold(input logic [9:0] d);
`ifdef VECTOR_TO_DEGREES_SIGNED_EN
    if (d[9]) return int'(d) - 1024 + 360;
`endif
    return int'(d);
  endfunction

  task automatic push_exp(input int x, input int y, input bit exact);
    real a;
    int  d;
    if (x == 0 && y == 0) begin
      exp_q.push_back({exact, 1'b1, 10'd0});
    end else begin
      a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
      d = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
      if (d < 0) d += 360;
      if (d >= 360) d -= 360;
      exp_q.push_back({exact, 1'b0, 10'(d)});
    end
  endtask

  task automatic send(input int x, input int y);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    x_in     = 8'(x);
    y_in     = 8'(y);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic check_out();
    logic [11:0] e;
    int          diff;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("zero_vec", zero_vec, e[10]);
      if (e[11]) begin
        chk("degrees", degrees, fold(e[9:0]));
      end else begin
        diff = (unfold(degrees) - int'(e[9:0]) + 720) % 360;
        if (!(diff <= 1 || diff == 359))
          $display("  vector x=%0d y=%0d got=%0d ref=%0d", $signed(x_in), $signed(y_in),
                   unfold(degrees), e[9:0]);
        chk("degrees_within_1", (diff <= 1 || diff == 359), 1);
      end
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_retired", out_valid, 0);
    chk("zero_vec_cleared", zero_vec, 0);
  endtask

  task automatic txn(input int x, input int y, input bit exact);
    int lat;
    push_exp(x, y, exact);
    send(x, y);
    wait_out(lat);
    chk("latency", lat, 12);
    check_out();
    retire();
  endtask

  initial begin
    logic [9:0] held_deg;
    logic [7:0] rx, ry;
    int         ax, ay, lat, quiet;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_degrees", degrees, 0);
    chk("rst_zero_vec", zero_vec, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Axis, diagonal and corner vectors
    txn(100, 0, 1'b1);
    txn(0, 100, 1'b1);
    txn(-100, 0, 1'b1);
    txn(0, -100, 1'b1);
    txn(71, 71, 1'b1);
    txn(-50, -87, 1'b1);
    txn(-128, -128, 1'b1);

    // Zero vector keeps the same latency, flag clears on the next result
    txn(0, 0, 1'b1);
    txn(100, 0, 1'b1);

    // Backpressure with the next input already waiting
    push_exp(0, 100, 1'b1);
    send(0, 100);
    wait_out(lat);
    chk("bp_latency", lat, 12);
    check_out();
    held_deg = degrees;
    push_exp(100, 0, 1'b1);
    in_valid = 1'b1;
    x_in     = 8'd100;
    y_in     = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_degrees", degrees, held_deg);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_retire_out_valid", out_valid, 0);
    chk("bp_retire_no_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_next", busy, 1);
    wait_out(lat);
    chk("bp_next_latency", lat, 12);
    check_out();
    retire();

    // Reset in the middle of the iterations
    send(0, 100);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    quiet = 1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) quiet = 0;
    end
    chk("midrst_no_result", quiet, 1);
    txn(100, 0, 1'b1);

    // Random vectors with max(|x|,|y|) >= 8
    for (int k = 0; k < 60; k++) begin
      do begin
        rx = 8'($urandom_range(0, 255));
        ry = 8'($urandom_range(0, 255));
        ax = ($signed(rx) < 0) ? -int'($signed(rx)) : int'($signed(rx));
        ay = ($signed(ry) < 0) ? -int'($signed(ry)) : int'($signed(ry));
      end while (ax < 8 && ay < 8);
      txn(int'($signed(rx)), int'($signed(ry)), 1'b0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
